// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types,
// status-register bit positions and the rotate helper used for operand 2.
package exe_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // Rotating a doubled word keeps the wrapped bits in the low half.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] d;
    d = {x, x} >> amt;
    return d[31:0];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: result and {N,Z,C,V}. Undefined commands return zero and
// pass the incoming flags through so a flag update leaves SR unchanged.
module alu
  import exe_pkg::*;
(
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [3:0]  exe_cmd,
  input  logic        carry_in,
  input  logic [3:0]  sr_in,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [32:0] sum_s;
  logic        is_logic_s;
  logic        is_add_s;
  logic        is_sub_s;

  // Operation select; subtraction is done as Rn + ~Val2 + carry so C means no-borrow.
  always_comb begin
    sum_s      = 33'd0;
    result     = 32'd0;
    is_logic_s = 1'b0;
    is_add_s   = 1'b0;
    is_sub_s   = 1'b0;
    case (exe_cmd)
      CMD_MOV: begin result = val2;          is_logic_s = 1'b1; end
      CMD_MVN: begin result = ~val2;         is_logic_s = 1'b1; end
      CMD_AND: begin result = val1 & val2;   is_logic_s = 1'b1; end
      CMD_ORR: begin result = val1 | val2;   is_logic_s = 1'b1; end
      CMD_EOR: begin result = val1 ^ val2;   is_logic_s = 1'b1; end
      CMD_ADD: begin
        sum_s    = {1'b0, val1} + {1'b0, val2};
        result   = sum_s[31:0];
        is_add_s = 1'b1;
      end
      CMD_ADC: begin
        sum_s    = {1'b0, val1} + {1'b0, val2} + {32'd0, carry_in};
        result   = sum_s[31:0];
        is_add_s = 1'b1;
      end
      CMD_SUB: begin
        sum_s    = {1'b0, val1} + {1'b0, ~val2} + 33'd1;
        result   = sum_s[31:0];
        is_sub_s = 1'b1;
      end
      CMD_SBC: begin
        sum_s    = {1'b0, val1} + {1'b0, ~val2} + {32'd0, carry_in};
        result   = sum_s[31:0];
        is_sub_s = 1'b1;
      end
      default: result = 32'd0;
    endcase
  end

  // Flag generation from the selected operation class.
  always_comb begin
    flags = sr_in;
    if (is_logic_s || is_add_s || is_sub_s) begin
      flags[SR_N] = result[31];
      flags[SR_Z] = (result == 32'd0);
    end else begin
      flags = sr_in;
    end
    if (is_add_s) begin
      flags[SR_C] = sum_s[32];
      flags[SR_V] = (val1[31] == val2[31]) && (result[31] != val1[31]);
    end else if (is_sub_s) begin
      flags[SR_C] = sum_s[32];
      flags[SR_V] = (val1[31] != val2[31]) && (result[31] != val1[31]);
    end else begin
      flags[SR_C] = sr_in[SR_C];
      flags[SR_V] = sr_in[SR_V];
    end
  end

endmodule

// File: rtl/exe_module.sv
// Execute stage: operand-2 generation, ALU, status register, combinational
// branch target and the EXE/MEM pipeline register.
module exe_module
  import exe_pkg::*;
#(
  parameter logic [3:0] SR_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic [3:0]  EXE_CMD,
  input  logic        imm,
  input  logic [31:0] PC_IN,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest_IN,
  output logic        Branch_taken,
  output logic [31:0] Branch_Address,
  output logic [3:0]  SR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] ST_Val,
  output logic [3:0]  Dest
);

  logic [31:0] val2_s;
  logic [4:0]  shamt_s;
  logic [31:0] alu_res_s;
  logic [3:0]  alu_flags_s;
  logic [3:0]  sr_r;
  logic        wb_en_r;
  logic        mem_r_en_r;
  logic        mem_w_en_r;
  logic [31:0] alu_res_r;
  logic [31:0] st_val_r;
  logic [3:0]  dest_r;

  assign shamt_s = Shift_operand[11:7];

  // Operand 2: rotated immediate, raw 12-bit memory offset, or shifted Rm.
  always_comb begin
    val2_s = 32'd0;
    if (imm) begin
      val2_s = ror32({24'd0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});
    end else if (MEM_R_EN_IN || MEM_W_EN_IN) begin
      val2_s = {20'd0, Shift_operand};
    end else if (shamt_s == 5'd0) begin
      val2_s = Val_Rm;
    end else begin
      case (shift_e'(Shift_operand[6:5]))
        SH_LSL:  val2_s = Val_Rm << shamt_s;
        SH_LSR:  val2_s = Val_Rm >> shamt_s;
        SH_ASR:  val2_s = $unsigned($signed(Val_Rm) >>> shamt_s);
        SH_ROR:  val2_s = ror32(Val_Rm, shamt_s);
        default: val2_s = Val_Rm;
      endcase
    end
  end

  alu u_alu (
    .val1     (Val_Rn),
    .val2     (val2_s),
    .exe_cmd  (EXE_CMD),
    .carry_in (sr_r[SR_C]),
    .sr_in    (sr_r),
    .result   (alu_res_s),
    .flags    (alu_flags_s)
  );

  // Branch target is word-offset relative to PC+4 and deliberately ignores rst.
  assign Branch_taken   = B_IN;
  assign Branch_Address = PC_IN + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

  // Status register and EXE/MEM pipeline register; a branch never reaches memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r       <= SR_RESET;
      wb_en_r    <= 1'b0;
      mem_r_en_r <= 1'b0;
      mem_w_en_r <= 1'b0;
      alu_res_r  <= 32'd0;
      st_val_r   <= 32'd0;
      dest_r     <= 4'd0;
    end else begin
      if (S_IN) begin
        sr_r <= alu_flags_s;
      end else begin
        sr_r <= sr_r;
      end
      wb_en_r    <= WB_EN_IN;
      mem_r_en_r <= MEM_R_EN_IN & ~B_IN;
      mem_w_en_r <= MEM_W_EN_IN & ~B_IN;
      alu_res_r  <= alu_res_s;
      st_val_r   <= Val_Rm;
      dest_r     <= Dest_IN;
    end
  end

  assign SR       = sr_r;
  assign WB_EN    = wb_en_r;
  assign MEM_R_EN = mem_r_en_r;
  assign MEM_W_EN = mem_w_en_r;
  assign ALU_Res  = alu_res_r;
  assign ST_Val   = st_val_r;
  assign Dest     = dest_r;

endmodule

// File: tb/tb_exe_module.sv
// Scoreboard bench for exe_module: directed corner cases then random ops,
// expected values from an arithmetic reference model.
module tb_exe_module;

  typedef struct {
    logic        rst, wb, mr, mw, b, s, imm;
    logic [3:0]  cmd, dest;
    logic [31:0] pc, rn, rm;
    logic [11:0] so;
    logic [23:0] simm;
  } stim_t;

  typedef struct {
    logic [31:0] res, st;
    logic [3:0]  dest, sr;
    logic        wb, mr, mw;
  } exp_t;

  logic clk = 1'b0;
  logic rst, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm;
  logic [3:0] EXE_CMD, Dest_IN;
  logic [31:0] PC_IN, Val_Rn, Val_Rm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic Branch_taken, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] Branch_Address, ALU_Res, ST_Val;
  logic [3:0] SR, Dest;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb_q[$];
  logic [3:0] model_sr = 4'b0000;

  always #5 clk = ~clk;

  exe_module #(.SR_RESET(4'b0000)) dut (
    .clk(clk), .rst(rst), .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN),
    .MEM_W_EN_IN(MEM_W_EN_IN), .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD(EXE_CMD),
    .imm(imm), .PC_IN(PC_IN), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest_IN(Dest_IN),
    .Branch_taken(Branch_taken), .Branch_Address(Branch_Address), .SR(SR),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .ST_Val(ST_Val), .Dest(Dest)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model_val2(input stim_t t);
    int amt;
    if (t.imm) return rotr({24'd0, t.so[7:0]}, 2 * int'(t.so[11:8]));
    if (t.mr || t.mw) return {20'd0, t.so};
    amt = int'(t.so[11:7]);
    if (amt == 0) return t.rm;
    case (t.so[6:5])
      2'd0:    return t.rm << amt;
      2'd1:    return t.rm >> amt;
      2'd2:    return $unsigned($signed(t.rm) >>> amt);
      default: return rotr(t.rm, amt);
    endcase
  endfunction

  // Reference ALU with 64-bit integer arithmetic; overflow is a range check.
  task automatic model_alu(input stim_t t, input logic [3:0] sr_in,
                           output logic [31:0] res, output logic [3:0] sr_out);
    logic [31:0] b;
    longint unsigned ua, ub, u;
    longint sa, sb, sv;
    longint cin;
    logic n_c, n_v;
    bit arith, known;
    b = model_val2(t);
    ua = {32'd0, t.rn}; ub = {32'd0, b};
    sa = longint'($signed(t.rn)); sb = longint'($signed(b));
    cin = longint'(sr_in[1]);
    arith = 1'b1; known = 1'b1; res = 32'd0; n_c = sr_in[1]; n_v = sr_in[0];
    case (t.cmd)
      4'b0010, 4'b0011: begin
        if (t.cmd == 4'b0010) cin = 0;
        u = ua + ub + longint'(cin); res = u[31:0]; n_c = u[32];
        sv = sa + sb + cin;
        n_v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        cin = (t.cmd == 4'b0100) ? 0 : 1 - cin;
        res = t.rn - b - 32'(cin);
        n_c = (ua >= ub + longint'(cin));
        sv = sa - sb - cin;
        n_v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'b0001: begin res = b;        arith = 1'b0; end
      4'b1001: begin res = ~b;       arith = 1'b0; end
      4'b0110: begin res = t.rn & b; arith = 1'b0; end
      4'b0111: begin res = t.rn | b; arith = 1'b0; end
      4'b1000: begin res = t.rn ^ b; arith = 1'b0; end
      default: begin known = 1'b0; arith = 1'b0; end
    endcase
    if (!arith) begin n_c = sr_in[1]; n_v = sr_in[0]; end
    if (known) sr_out = {res[31], res == 32'd0, n_c, n_v};
    else       sr_out = sr_in;
  endtask

  // Drive one op, check the combinational branch outputs, queue the registered result.
  task automatic issue(input stim_t t, input bit use_k, input logic [31:0] k_res,
                       input logic [3:0] k_sr);
    exp_t e;
    logic [31:0] res;
    logic [3:0] nsr;
    logic [31:0] baddr;
    @(negedge clk);
    rst = t.rst; WB_EN_IN = t.wb; MEM_R_EN_IN = t.mr; MEM_W_EN_IN = t.mw;
    B_IN = t.b; S_IN = t.s; EXE_CMD = t.cmd; imm = t.imm; PC_IN = t.pc;
    Val_Rn = t.rn; Val_Rm = t.rm; Shift_operand = t.so; Signed_imm_24 = t.simm;
    Dest_IN = t.dest;
    #1;
    baddr = t.pc + 32'(int'($signed(t.simm)) * 4);
    chk("branch_taken", {31'd0, Branch_taken}, {31'd0, t.b});
    chk("branch_addr", Branch_Address, baddr);
    model_alu(t, model_sr, res, nsr);
    if (t.rst) begin
      model_sr = 4'b0000;
      e = '{res: 32'd0, st: 32'd0, dest: 4'd0, sr: 4'b0000, wb: 1'b0, mr: 1'b0, mw: 1'b0};
    end else begin
      if (use_k) begin res = k_res; nsr = t.s ? k_sr : model_sr; end
      if (t.s) model_sr = nsr;
      e = '{res: res, st: t.rm, dest: t.dest, sr: model_sr,
            wb: t.wb, mr: t.mr & ~t.b, mw: t.mw & ~t.b};
    end
    sb_q.push_back(e);
  endtask

  function automatic stim_t blank();
    stim_t t;
    t = '{rst: 1'b0, wb: 1'b0, mr: 1'b0, mw: 1'b0, b: 1'b0, s: 1'b0, imm: 1'b0,
          cmd: 4'd0, dest: 4'd0, pc: 32'd0, rn: 32'd0, rm: 32'd0, so: 12'd0, simm: 24'd0};
    return t;
  endfunction

  // Monitor: every registered output compared one edge after its op was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alu_res", ALU_Res, e.res);
        chk("st_val", ST_Val, e.st);
        chk("dest", {28'd0, Dest}, {28'd0, e.dest});
        chk("sr", {28'd0, SR}, {28'd0, e.sr});
        chk("ctrl", {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, {29'd0, e.wb, e.mr, e.mw});
      end
    end
  end

  initial begin
    stim_t t;
    t = blank(); t.rst = 1'b1; t.rm = 32'hDEAD_BEEF; t.wb = 1'b1;
    issue(t, 1'b0, 32'd0, 4'd0);
    t = blank(); t.cmd = 4'b0001; t.imm = 1'b1; t.so = 12'h4FF; t.wb = 1'b1; t.dest = 4'd3;
    issue(t, 1'b1, 32'hFF00_0000, 4'b0000);
    t = blank(); t.cmd = 4'b0010; t.imm = 1'b1; t.so = 12'h001; t.rn = 32'h7FFF_FFFF; t.s = 1'b1;
    issue(t, 1'b1, 32'h8000_0000, 4'b1001);
    t = blank(); t.cmd = 4'b0100; t.imm = 1'b1; t.so = 12'h005; t.rn = 32'd5; t.s = 1'b1;
    issue(t, 1'b1, 32'd0, 4'b0110);
    t = blank(); t.cmd = 4'b0011; t.imm = 1'b1; t.so = 12'h001; t.rn = 32'd1;
    issue(t, 1'b1, 32'd3, 4'b0110);
    t = blank(); t.cmd = 4'b0001; t.rm = 32'h8000_0000; t.so = 12'h240;
    issue(t, 1'b1, 32'hF800_0000, 4'b0110);
    t = blank(); t.cmd = 4'b0001; t.rm = 32'h0000_0001; t.so = 12'h0E0;
    issue(t, 1'b1, 32'h8000_0000, 4'b0110);
    t = blank(); t.b = 1'b1; t.pc = 32'h100; t.simm = 24'hFFFFFE; t.cmd = 4'b0010;
    t.imm = 1'b1; t.s = 1'b1;
    issue(t, 1'b1, 32'd0, 4'b0100);
    t = blank(); t.rst = 1'b1; t.s = 1'b1; t.cmd = 4'b0010; t.rn = 32'h8000_0000;
    t.imm = 1'b1; t.so = 12'h0FF; t.wb = 1'b1; t.mw = 1'b1; t.dest = 4'hF; t.rm = 32'h55;
    issue(t, 1'b0, 32'd0, 4'd0);
    t = blank(); t.cmd = 4'b0001; t.imm = 1'b1; t.so = 12'h02A; t.wb = 1'b1; t.dest = 4'd7;
    issue(t, 1'b1, 32'h0000_002A, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      t = blank();
      t.rst  = ($urandom_range(0, 49) == 0);
      t.b    = ($urandom_range(0, 7) == 0);
      t.s    = $urandom_range(0, 1);
      t.imm  = ($urandom_range(0, 3) == 0);
      t.cmd  = 4'($urandom_range(0, 15));
      t.dest = 4'($urandom);
      t.pc   = $urandom;
      t.rn   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      t.rm   = $urandom;
      t.so   = 12'($urandom);
      t.simm = 24'($urandom);
      if (!t.b) begin
        t.wb = $urandom_range(0, 1);
        t.mr = ($urandom_range(0, 5) == 0);
        t.mw = !t.mr && ($urandom_range(0, 5) == 0);
      end else begin
        t.wb = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
      end
      issue(t, 1'b0, 32'd0, 4'd0);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
